fir_decim: RTL and testbench

FIR_DECIM -- requirements
Module: fir_decim

---
 rtl/fir_decim.sv | 102 ++++++++++
 tb/tb_fir_decim.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim.sv
// Decimating FIR filter: reads DECIM samples, runs a serial TAPS-cycle MAC over a
// fixed Q10 coefficient table, then writes one filtered sample to the output FIFO.
module fir_decim #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 8,
  parameter int DECIM      = 4,
  parameter int Q_BITS     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic                  x_in_empty,
  output logic                  x_in_rd_en,
  output logic [DATA_WIDTH-1:0] y_out,
  input  logic                  y_out_full,
  output logic                  y_out_wr_en
);

  localparam int ACC_W = 64;
  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_RD  = IDX_W'(DECIM - 1);
  localparam logic [IDX_W-1:0] LAST_MAC = IDX_W'(TAPS - 1);

  typedef enum logic [1:0] {S_READ, S_MAC, S_WRITE} state_t;

  state_t                        state;
  logic signed [DATA_WIDTH-1:0]  taps_q [TAPS];
  logic        [IDX_W-1:0]       rd_cnt;
  logic        [IDX_W-1:0]       mac_idx;
  logic signed [ACC_W-1:0]       acc;
  logic signed [ACC_W-1:0]       prod;
  logic signed [ACC_W-1:0]       acc_next;

  // Symmetric low-pass, coefficients sum to 1024 (unity DC gain in Q10).
  function automatic logic signed [15:0] coef(input logic [IDX_W-1:0] idx);
    case (int'(idx))
      0, 7:    coef = -16'sd12;
      1, 6:    coef = 16'sd40;
      2, 5:    coef = 16'sd150;
      3, 4:    coef = 16'sd334;
      default: coef = 16'sd0;
    endcase
  endfunction

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    prod     = ACC_W'(taps_q[mac_idx]) * ACC_W'(coef(mac_idx));
    acc_next = acc + prod;
  end

  // Handshakes are combinational from state so a pop or write happens in the same
  // cycle the FIFO flag allows it; reset gates them off immediately.
  assign x_in_rd_en  = !rst && (state == S_READ)  && !x_in_empty;
  assign y_out_wr_en = !rst && (state == S_WRITE) && !y_out_full;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_READ;
      rd_cnt  <= '0;
      mac_idx <= '0;
      acc     <= '0;
      y_out   <= '0;
      // NOTE: the delay line is a handful of flops, not a RAM, so it is reset so the
      // first output after reset sees zeros in unfilled positions.
      for (int k = 0; k < TAPS; k++) taps_q[k] <= '0;
    end else begin
      case (state)
        S_READ: begin
          if (x_in_rd_en) begin
            for (int k = TAPS - 1; k > 0; k--) taps_q[k] <= taps_q[k-1];
            taps_q[0] <= x_in;
            if (rd_cnt == LAST_RD) begin
              rd_cnt  <= '0;
              acc     <= '0;
              mac_idx <= '0;
              state   <= S_MAC;
            end else begin
              rd_cnt <= rd_cnt + IDX_W'(1);
            end
          end
        end
        S_MAC: begin
          acc <= acc_next;
          if (mac_idx == LAST_MAC) begin
            y_out   <= DATA_WIDTH'(acc_next >>> Q_BITS);
            mac_idx <= '0;
            state   <= S_WRITE;
          end else begin
            mac_idx <= mac_idx + IDX_W'(1);
          end
        end
        S_WRITE: begin
          if (y_out_wr_en) state <= S_READ;
        end
        default: state <= S_READ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_decim.sv
// Directed bench for fir_decim: FIFO models on both sides and a reference filter model
// that pushes expected outputs to a scoreboard as samples are queued.
module tb_fir_decim;

  localparam int DW    = 32;
  localparam int TAPS  = 8;
  localparam int DECIM = 4;
  localparam int QB    = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [DW-1:0] x_in = '0;
  logic                 x_in_empty = 1'b1;
  logic                 x_in_rd_en;
  logic signed [DW-1:0] y_out;
  logic                 y_out_full = 1'b0;
  logic                 y_out_wr_en;

  fir_decim #(.DATA_WIDTH(DW), .TAPS(TAPS), .DECIM(DECIM), .Q_BITS(QB)) dut (
    .clk         (clk),
    .rst         (rst),
    .x_in        (x_in),
    .x_in_empty  (x_in_empty),
    .x_in_rd_en  (x_in_rd_en),
    .y_out       (y_out),
    .y_out_full  (y_out_full),
    .y_out_wr_en (y_out_wr_en)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int in_q [$];
  int exp_q [$];
  longint mline [TAPS];
  int mcount = 0;
  const longint MCOEF [TAPS] = '{-12, 40, 150, 334, 334, 150, 40, -12};

  int cyc = 0;
  int last_pop_cyc = 0;
  int last_wr_cyc = 0;
  bit have_prev_wr = 0;
  bit check_lat = 0;
  bit check_period = 0;
  bit last_wr_seen = 0;
  logic signed [DW-1:0] held;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) mline[k] = 0;
    mcount = 0;
    exp_q.delete();
  endtask

  // Queue a sample for the input FIFO and advance the reference filter.
  task automatic send(input int s);
    longint acc;
    in_q.push_back(s);
    for (int k = TAPS - 1; k > 0; k--) mline[k] = mline[k-1];
    mline[0] = longint'(s);
    mcount++;
    if (mcount == DECIM) begin
      mcount = 0;
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += mline[k] * MCOEF[k];
      exp_q.push_back(int'(acc >>> QB));
    end
  endtask

  task automatic drive();
    x_in_empty = (in_q.size() == 0);
    x_in       = (in_q.size() != 0) ? in_q[0] : '0;
  endtask

  // One clock: observe at the falling edge, update FIFO models just after the rising edge.
  task automatic tick();
    bit popping;
    @(negedge clk);
    popping      = (x_in_rd_en === 1'b1);
    last_wr_seen = (y_out_wr_en === 1'b1);
    if (popping || last_wr_seen) check("rd_wr_exclusive", x_in_rd_en & y_out_wr_en, 0);
    if (popping) last_pop_cyc = cyc;
    if (last_wr_seen) begin
      if (exp_q.size() == 0) check("unexpected_write", 1, 0);
      else check("y_out", y_out, exp_q.pop_front());
      if (check_lat) check("latency", cyc - last_pop_cyc, TAPS + 1);
      if (check_period && have_prev_wr) check("period", cyc - last_wr_cyc, DECIM + TAPS + 1);
      last_wr_cyc  = cyc;
      have_prev_wr = 1;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (popping && in_q.size() != 0) void'(in_q.pop_front());
    drive();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || in_q.size() != 0); i++) tick();
    check("drain_done", exp_q.size() + in_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset with data available and no clock edge: outputs forced at once.
    in_q.push_back(99);
    drive();
    #2 rst = 1'b1;
    #1;
    check("reset_y_out", y_out, 0);
    check("reset_rd_en", x_in_rd_en, 0);
    check("reset_wr_en", y_out_wr_en, 0);
    in_q.delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_pop_when_empty", x_in_rd_en, 0);
    end

    // Impulse: 334, -12, 0, 0.
    check_lat = 1;
    send(1024);
    for (int i = 0; i < 15; i++) send(0);
    drive();
    drain();

    // DC: 512 then 1024; then -1 steady state, with back-to-back throughput.
    check_period = 1;
    have_prev_wr = 0;
    for (int i = 0; i < 16; i++) send(1024);
    for (int i = 0; i < 16; i++) send(-1);
    drive();
    drain();
    check_period = 0;

    // Back-pressure held 20 cycles at S_WRITE entry.
    check_lat = 0;
    y_out_full = 1'b1;
    send(100); send(-200); send(300); send(-400);
    send(5);   send(6);    send(7);   send(8);
    drive();
    repeat (DECIM + TAPS) tick();
    held = y_out;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_wr_en", y_out_wr_en, 0);
      check("bp_rd_en", x_in_rd_en, 0);
      check("bp_y_stable", y_out, held);
    end
    y_out_full = 1'b0;
    tick();
    check("bp_write_after_release", last_wr_seen, 1);
    drain();

    // Input starvation after 2 of 4 samples.
    check_lat = 1;
    send(2048); send(-3000);
    drive();
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("starve_rd_en", x_in_rd_en, 0);
      check("starve_wr_en", y_out_wr_en, 0);
    end
    send(777); send(-1);
    drive();
    drain();

    // Reset during the third MAC cycle discards the pending result.
    send(7); send(7); send(7); send(7);
    drive();
    repeat (DECIM + 2) tick();
    rst = 1'b1;
    model_reset();
    #1;
    check("midmac_reset_y_out", y_out, 0);
    check("midmac_reset_wr_en", y_out_wr_en, 0);
    #2 rst = 1'b0;
    repeat (15) tick();
    send(1024); send(0); send(0); send(0);
    drive();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
